// File: rtl/stopwatch_counter_if.sv
// Bundles the stopwatch control inputs and display outputs.
// Signalling: there is no valid/ready handshake on this block. clk_1hz and
// clk_2hz are free-running levels whose rising edges are detected inside the
// counter; pause is a single-cycle pulse; adj and sel are levels sampled every
// cycle. All slave outputs are registered and change only on the clock edge.
interface stopwatch_counter_if;
  logic       clk_1hz;
  logic       clk_2hz;
  logic       pause;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       adjusting;
  logic [1:0] state_dbg;

  modport master (
    output clk_1hz, clk_2hz, pause, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, running, adjusting, state_dbg
  );

  modport slave (
    input  clk_1hz, clk_2hz, pause, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, running, adjusting, state_dbg
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run, pause and adjust modes. Rising edges of the
// divided 1 Hz / 2 Hz square waves become single-cycle ticks; 1 Hz ticks run
// the full carry chain in RUN, 2 Hz ticks step one field in ADJUST.
module stopwatch_counter #(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  sw
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] TENS_MAX = 4'(MAX_TENS);
  localparam logic [3:0] ONES_MAX = 4'(MAX_ONES);

  state_t     state_q, state_d;
  logic       paused_flag_q, paused_flag_d;
  logic       prev_1hz_q, prev_2hz_q;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       running_q, adjusting_q;
  logic       tick_1hz, tick_2hz;
  logic       sec_wrap;

  // One BCD field stepped as a 00..MAX counter; returns {tens, ones}.
  function automatic logic [7:0] inc_field(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones == ONES_MAX) begin
      if (tens == TENS_MAX) r = 8'h00;
      else                  r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

  assign tick_1hz = sw.clk_1hz & ~prev_1hz_q;
  assign tick_2hz = sw.clk_2hz & ~prev_2hz_q;
  assign sec_wrap = (sec_tens_q == TENS_MAX) && (sec_ones_q == ONES_MAX);

  // Next-state and digit update; priority is adj > pause > tick.
  always_comb begin
    state_d       = state_q;
    paused_flag_d = paused_flag_q;
    min_tens_d    = min_tens_q;
    min_ones_d    = min_ones_q;
    sec_tens_d    = sec_tens_q;
    sec_ones_d    = sec_ones_q;
    case (state_q)
      ADJUST: begin
        if (!sw.adj) begin
          // Leaving adjust restores the run/pause choice; inputs that cycle are dropped.
          state_d = paused_flag_q ? PAUSED : RUN;
        end else begin
          if (sw.pause) paused_flag_d = ~paused_flag_q;
          if (tick_2hz) begin
            if (sw.sel) {sec_tens_d, sec_ones_d} = inc_field(sec_tens_q, sec_ones_q);
            else        {min_tens_d, min_ones_d} = inc_field(min_tens_q, min_ones_q);
          end
        end
      end
      RUN: begin
        if (sw.adj) begin
          state_d = ADJUST;
        end else begin
          // A tick coinciding with pause is still counted before stopping.
          if (tick_1hz) begin
            {sec_tens_d, sec_ones_d} = inc_field(sec_tens_q, sec_ones_q);
            if (sec_wrap) {min_tens_d, min_ones_d} = inc_field(min_tens_q, min_ones_q);
          end
          if (sw.pause) begin
            state_d       = PAUSED;
            paused_flag_d = 1'b1;
          end
        end
      end
      default: begin
        if (sw.adj) begin
          state_d = ADJUST;
        end else if (sw.pause) begin
          state_d       = RUN;
          paused_flag_d = 1'b0;
        end
      end
    endcase
  end

  // State, edge-detect history, digits and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PAUSED;
      paused_flag_q <= 1'b1;
      prev_1hz_q    <= 1'b0;
      prev_2hz_q    <= 1'b0;
      min_tens_q    <= 4'd0;
      min_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      sec_ones_q    <= 4'd0;
      running_q     <= 1'b0;
      adjusting_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      paused_flag_q <= paused_flag_d;
      prev_1hz_q    <= sw.clk_1hz;
      prev_2hz_q    <= sw.clk_2hz;
      min_tens_q    <= min_tens_d;
      min_ones_q    <= min_ones_d;
      sec_tens_q    <= sec_tens_d;
      sec_ones_q    <= sec_ones_d;
      running_q     <= (state_d == RUN);
      adjusting_q   <= (state_d == ADJUST);
    end
  end

  assign sw.min_tens  = min_tens_q;
  assign sw.min_ones  = min_ones_q;
  assign sw.sec_tens  = sec_tens_q;
  assign sw.sec_ones  = sec_ones_q;
  assign sw.running   = running_q;
  assign sw.adjusting = adjusting_q;
  assign sw.state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed walk through the stopwatch use cases
// followed by randomized control traffic, every cycle compared against a
// minutes/seconds integer model.
module tb_stopwatch_counter;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_counter_if sw();

  stopwatch_counter #(.MAX_TENS(5), .MAX_ONES(9)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Reference model: plain integer minutes/seconds and a mode number
  // (0 paused, 1 running, 2 adjusting).
  int m_min, m_sec, m_mode;
  bit m_flag, m_prev1, m_prev2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_exp();
    return {14'd0, 4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            (m_mode == 1), (m_mode == 2)};
  endfunction

  function automatic logic [31:0] obs_all();
    return {14'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.running, sw.adjusting};
  endfunction

  function automatic logic [31:0] digits();
    return {16'd0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  task automatic model_step();
    bit t1, t2;
    int total;
    t1 = sw.clk_1hz && !m_prev1;
    t2 = sw.clk_2hz && !m_prev2;
    m_prev1 = sw.clk_1hz;
    m_prev2 = sw.clk_2hz;
    if (rst) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_flag = 1; m_prev1 = 0; m_prev2 = 0;
    end else if (sw.adj && m_mode != 2) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (!sw.adj) m_mode = m_flag ? 0 : 1;
      else begin
        if (sw.pause) m_flag = !m_flag;
        if (t2) begin
          if (sw.sel) m_sec = (m_sec + 1) % 60;
          else        m_min = (m_min + 1) % 60;
        end
      end
    end else if (m_mode == 1) begin
      if (t1) begin
        total = (m_min * 60 + m_sec + 1) % 3600;
        m_min = total / 60;
        m_sec = total % 60;
      end
      if (sw.pause) begin m_mode = 0; m_flag = 1; end
    end else if (sw.pause) begin
      m_mode = 1; m_flag = 0;
    end
    exp_q.push_back(pack_exp());
  endtask

  // Driver tasks
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cyc", obs_all(), exp_q.pop_front());
  endtask

  task automatic rise1(input int hold);
    sw.clk_1hz = 1'b1;
    repeat (hold) cycle();
    sw.clk_1hz = 1'b0;
    repeat (hold) cycle();
  endtask

  task automatic rise2();
    sw.clk_2hz = 1'b1;
    repeat (2) cycle();
    sw.clk_2hz = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic pulse_pause();
    sw.pause = 1'b1;
    cycle();
    sw.pause = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    sw.clk_1hz = 1'b0; sw.clk_2hz = 1'b0; sw.pause = 1'b0; sw.adj = 1'b0; sw.sel = 1'b0;
    m_min = 0; m_sec = 0; m_mode = 0; m_flag = 1; m_prev1 = 0; m_prev2 = 0;

    // Reset, then ticks while paused are ignored
    repeat (2) cycle();
    check("reset_state", obs_all(), 32'h0);
    rst = 1'b0;
    repeat (3) rise1(10);
    check("paused_digits", digits(), 32'h0000);
    check("paused_running", {31'd0, sw.running}, 32'd0);

    // Run for 65 seconds
    pulse_pause();
    repeat (65) rise1(10);
    check("run_0105", digits(), 32'h0105);
    check("run_running", {31'd0, sw.running}, 32'd1);

    // Restart from zero in RUN, then adjust seconds and minutes
    rst = 1'b1; repeat (2) cycle(); rst = 1'b0;
    pulse_pause();
    sw.adj = 1'b1; sw.sel = 1'b1; cycle();
    check("adj_flag", {30'd0, sw.running, sw.adjusting}, 32'd1);
    repeat (61) rise2();
    check("adj_sec_wrap", digits(), 32'h0001);
    sw.sel = 1'b0;
    repeat (59) rise2();
    check("adj_min_5901", digits(), 32'h5901);
    sw.adj = 1'b0; cycle();
    check("adj_exit_run", {30'd0, sw.running, sw.adjusting}, 32'd2);

    // Preload 59:58 and roll over
    sw.adj = 1'b1; sw.sel = 1'b1; cycle();
    repeat (57) rise2();
    sw.adj = 1'b0; cycle();
    check("preload_5958", digits(), 32'h5958);
    rise1(10);
    check("roll_5959", digits(), 32'h5959);
    rise1(10);
    check("roll_0000", digits(), 32'h0000);

    // Pause coinciding with a tick at 00:10
    repeat (10) rise1(10);
    check("at_0010", digits(), 32'h0010);
    sw.clk_1hz = 1'b1; sw.pause = 1'b1; cycle();
    sw.pause = 1'b0;
    check("pause_tick_0011", digits(), 32'h0011);
    check("pause_tick_state", {31'd0, sw.running}, 32'd0);
    repeat (9) cycle();
    sw.clk_1hz = 1'b0; repeat (10) cycle();
    repeat (5) rise1(10);
    check("paused_hold_0011", digits(), 32'h0011);

    // Set 12:34, run, then reset mid-count
    sw.adj = 1'b1; sw.sel = 1'b0; cycle();
    repeat (12) rise2();
    sw.sel = 1'b1;
    repeat (23) rise2();
    sw.adj = 1'b0; cycle();
    pulse_pause();
    check("set_1234", digits(), 32'h1234);
    sw.clk_1hz = 1'b1; repeat (3) cycle();
    rst = 1'b1; cycle();
    check("mid_reset", obs_all(), 32'h0);
    rst = 1'b0; sw.clk_1hz = 1'b0; cycle();

    // Pause inside ADJUST flips the state restored on exit
    pulse_pause();
    sw.adj = 1'b1; cycle();
    pulse_pause();
    sw.adj = 1'b0; cycle();
    check("adj_toggle_to_paused", {30'd0, sw.running, sw.adjusting}, 32'd0);
    sw.adj = 1'b1; cycle();
    pulse_pause();
    sw.adj = 1'b0; cycle();
    check("adj_toggle_to_run", {30'd0, sw.running, sw.adjusting}, 32'd2);

    // Randomized control traffic; adj only changes on quiet cycles
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        sw.adj = ~sw.adj;
        sw.pause = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) sw.clk_1hz = ~sw.clk_1hz;
        if ($urandom_range(0, 3) == 0) sw.clk_2hz = ~sw.clk_2hz;
        sw.pause = !sw.pause && ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) sw.sel = ~sw.sel;
      end
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Downstream consumer of the clock dividers. Turns the divided 1 Hz and 2 Hz square waves into single-cycle ticks by detecting their rising edges in the system clock domain. Drives an MM:SS BCD stopwatch with run, pause and adjust modes. Its digit outputs feed the 7-segment display mux.

Parameters:
MAX_TENS, 5, highest tens digit for both seconds and minutes (fields count 00..59)
MAX_ONES, 9, highest ones digit

Ports:
clk  input  1  system clock; same clock that drives the dividers
rst  input  1  synchronous, active-high reset
clk_1hz  input  1  1 Hz square wave from a divider, registered in clk domain
clk_2hz  input  1  2 Hz square wave from a divider, registered in clk domain
pause  input  1  single-cycle pulse (already debounced) that toggles run/pause
adj  input  1  level; 1 = adjust mode
sel  input  1  level; field to adjust in ADJUST: 0 = minutes, 1 = seconds
min_tens  output  4  BCD minutes tens, 0..5
min_ones  output  4  BCD minutes ones, 0..9
sec_tens  output  4  BCD seconds tens, 0..5
sec_ones  output  4  BCD seconds ones, 0..9
running  output  1  1 when state = RUN
adjusting  output  1  1 when state = ADJUST

Behaviour:
- Edge detect:
  - prev_1hz and prev_2hz are registered every cycle, in every state.
  - tick_1hz = clk_1hz & ~prev_1hz; tick_2hz = clk_2hz & ~prev_2hz.
  - Reset clears prev_* to 0.
  - A level held high produces exactly one tick.
- All outputs are registered. Reset values: all digits 0, running=0, adjusting=0, state=PAUSED, paused_flag=1.
- rst overrides everything else in the same cycle.
- States: PAUSED, RUN, ADJUST. paused_flag records the run/pause choice across ADJUST.
- Priority each cycle: rst > adj > pause > tick.
- Any state, adj=1: next state ADJUST. Ticks in the cycle adj first rises are dropped.
- ADJUST, adj falls: next state is PAUSED if paused_flag=1, otherwise RUN.
- pause pulse while adj=0:
  - PAUSED -> RUN, paused_flag=0.
  - RUN -> PAUSED, paused_flag=1.
- pause pulse in ADJUST: toggles paused_flag only; no state change.
- RUN, tick_1hz: increment seconds.
  - Carry chain: sec_ones 9->0 carries into sec_tens; sec_tens 5 (with ones 9) -> 0 carries into minutes; minutes carry the same way.
  - 59:59 -> 00:00, no overflow flag.
- RUN, tick_1hz and pause in the same cycle: the increment is applied, and state becomes PAUSED on the same edge.
- PAUSED: digits hold; ticks are ignored.
- ADJUST, tick_2hz: increment only the field chosen by sel, as a 00..59 counter.
  - 59 -> 00 with no carry into the other field.
  - tick_1hz is ignored.
  - A sel change takes effect on the next tick_2hz.
- BCD invariant: the counter never leaves the legal range (tens <= MAX_TENS, ones <= MAX_ONES).
- Latency: a tick edge seen at cycle n updates the digits at edge n+1. running and adjusting update on the same edge as the state.

Test Plan:
- rst 2 cycles, then 3 clk_1hz rises, pause=0 -> digits 00:00, running=0.
- One pause pulse, then 65 clk_1hz rises (clk_1hz held high for 10 cycles each time) -> 01:05, running=1; each rise adds exactly 1.
- adj=1, sel=1, 61 clk_2hz rises -> seconds go 00..59,00,01 and minutes are unchanged; then sel=0, 59 clk_2hz rises -> 59:01; adj=0 -> back to prior state.
- Preload 59:58 via adjust, in RUN, 2 clk_1hz rises -> 59:59 then 00:00.
- In RUN at 00:10, pause pulse in the same cycle as tick_1hz -> 00:11, then PAUSED; 5 more rises -> still 00:11, running=0.
- In RUN at 12:34, assert rst mid-count -> next edge 00:00, running=0, adjusting=0; a pause pulse during ADJUST followed by adj=0 -> returns to the opposite run/pause state.
